instr_sequencer: RTL and testbench

//  Fetch/decode/execute controller for the 16-bit processor. Owns PC and IR, reads program_rom,
//  and drives the register-file, ula, dram and output-register strobes of the datapath.

---
 rtl/proc_pkg.sv | 38 +++
 rtl/instr_decoder.sv | 25 ++
 rtl/instr_sequencer.sv | 89 ++++++++
 tb/tb_instr_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// proc_pkg: opcodes, sequencer states and datapath select codes shared across the processor
package proc_pkg;
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_NOT   = 4'h5;
  localparam logic [3:0] OP_XOR   = 4'h6;
  localparam logic [3:0] OP_NAND  = 4'h7;
  localparam logic [3:0] OP_NOR   = 4'h8;
  localparam logic [3:0] OP_LOAD  = 4'h9;
  localparam logic [3:0] OP_STORE = 4'hA;
  localparam logic [3:0] OP_PRINT = 4'hB;
  localparam logic [3:0] OP_LDM   = 4'hC;
  localparam logic [3:0] OP_IN    = 4'hD;
  localparam logic [3:0] OP_ILL   = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_FWAIT  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;
  localparam logic [1:0] SRC_IMM   = 2'd0;
  localparam logic [1:0] SRC_ULA   = 2'd1;
  localparam logic [1:0] SRC_RAM   = 2'd2;
  localparam logic [1:0] SRC_STDIN = 2'd3;
  localparam logic [1:0] REG_A     = 2'd0;
  localparam logic [1:0] REG_B     = 2'd1;
  localparam logic [1:0] REG_C     = 2'd2;
  localparam logic [1:0] REG_MADDR = 2'd3;
  function automatic logic is_alu(input logic [3:0] op);
    return op >= OP_ADD && op <= OP_NOR;
  endfunction
endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: classifies the instruction register into dispatch targets and write-back source
module instr_decoder
  import proc_pkg::*;
(
  input  logic [15:0] ir_i,
  output state_t      decode_next_o,
  output state_t      exec_next_o,
  output logic [1:0]  rf_src_o,
  output logic        illegal_o
);
  logic [3:0] op;
  // dispatch from DECODE, successor of EXEC, register-file data source
  always_comb begin
    op = ir_i[15:12];
    decode_next_o = op == OP_HALT ? S_HALT :
                    (op == OP_LOAD || op == OP_IN) ? S_WB :
                    (is_alu(op) || op == OP_LDM || op == OP_STORE || op == OP_PRINT) ? S_EXEC :
                    S_FETCH;
    exec_next_o = (op == OP_STORE || op == OP_PRINT) ? S_FETCH : S_WB;
    rf_src_o = op == OP_LOAD ? SRC_IMM :
               op == OP_LDM  ? SRC_RAM :
               op == OP_IN   ? SRC_STDIN : SRC_ULA;
    illegal_o = op == OP_ILL;
  end
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/execute controller owning PC, IR and the datapath strobes
module instr_sequencer
  import proc_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            step,
  output logic [PC_W-1:0] rom_addr,
  input  logic [15:0]     rom_data,
  output logic [3:0]      alu_op,
  output logic            rf_we,
  output logic [1:0]      rf_wsel,
  output logic [1:0]      rf_rsel,
  output logic [1:0]      rf_src,
  output logic [7:0]      imm,
  output logic [7:0]      ram_addr,
  output logic            ram_we,
  output logic            out_we,
  output logic [PC_W-1:0] pc,
  output logic [2:0]      state,
  output logic            halted,
  output logic            illegal
);
  state_t          state_q, state_d, dec_next, exec_next;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic            ill_q, ill_d, dec_ill;
  instr_decoder u_dec (
    .ir_i          (ir_q),
    .decode_next_o (dec_next),
    .exec_next_o   (exec_next),
    .rf_src_o      (rf_src),
    .illegal_o     (dec_ill)
  );
  assign rom_addr = pc_q;
  assign pc       = pc_q;
  assign state    = state_q;
  assign halted   = state_q == S_HALT;
  assign illegal  = ill_q;
  assign alu_op   = ir_q[15:12];
  assign rf_wsel  = ir_q[9:8];
  assign rf_rsel  = ir_q[9:8];
  assign imm      = ir_q[7:0];
  assign ram_addr = ir_q[7:0];
  // strobes are gated by rst so a write due in the reset cycle never reaches the datapath
  assign rf_we  = !rst && state_q == S_WB;
  assign ram_we = !rst && state_q == S_EXEC && ir_q[15:12] == OP_STORE;
  assign out_we = !rst && state_q == S_EXEC && ir_q[15:12] == OP_PRINT;
  // next-state, PC advance, IR capture and sticky illegal flag
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ill_d   = ill_q;
    case (state_q)
      S_FETCH:  state_d = (run || step) ? S_FWAIT : S_FETCH;
      S_FWAIT: begin
        ir_d    = rom_data;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = dec_next;
        pc_d    = dec_next == S_HALT ? pc_q : pc_q + 1'b1;
        ill_d   = ill_q | dec_ill;
      end
      S_EXEC:   state_d = exec_next;
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_HALT;
    endcase
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ill_q   <= ill_d;
    end
  end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed checks of sequencing, strobes, stepping, halt, wrap and reset
module tb_instr_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic [3:0]  alu_op;
  logic        rf_we, ram_we, out_we, halted, illegal;
  logic [1:0]  rf_wsel, rf_rsel, rf_src;
  logic [7:0]  imm, ram_addr, pc;
  logic [2:0]  state;
  logic [15:0] rom [256];
  int n_tests = 0;
  int n_fail = 0;

  instr_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .step     (step),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .alu_op   (alu_op),
    .rf_we    (rf_we),
    .rf_wsel  (rf_wsel),
    .rf_rsel  (rf_rsel),
    .rf_src   (rf_src),
    .imm      (imm),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .out_we   (out_we),
    .pc       (pc),
    .state    (state),
    .halted   (halted),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  // synchronous program ROM: data follows the sampled address by one cycle
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  // leaves the bench at the negedge of cycle 1 (first FETCH after reset)
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int cyc;
    logic ok;
    int n_ram, n_rf, n_out, n_ovl;
    logic [7:0] ram_a, rf_a, pc_hold;
    logic [1:0] rf_s, rf_w, rs_sel;

    // test 1: LOAD REGB,5
    clear_rom();
    rom[0] = 16'h9105;
    run = 1'b1;
    do_reset();
    check("rst_state", state, 0);
    check("rst_pc", pc, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_halted", halted, 0);
    check("rst_illegal", illegal, 0);
    check("rst_strobes", {rf_we, ram_we, out_we}, 0);
    tick();
    check("t1_fwait", state, 1);
    tick();
    check("t1_decode", state, 2);
    tick();
    check("t1_rf_we", rf_we, 1);
    check("t1_wsel", rf_wsel, 1);
    check("t1_src", rf_src, 0);
    check("t1_imm", imm, 5);
    check("t1_pc", pc, 1);
    tick();
    check("t1_fetch_again", state, 0);
    check("t1_rf_we_off", rf_we, 0);

    // test 2: ADD, five-cycle round trip
    clear_rom();
    rom[0] = 16'h1000;
    do_reset();
    tick(2);
    check("t2_alu_op", alu_op, 1);
    tick();
    check("t2_exec", {state, rf_we}, {3'd3, 1'b0});
    tick();
    check("t2_rf_we", rf_we, 1);
    check("t2_src", rf_src, 1);
    tick();
    check("t2_fetch_c6", state, 0);

    // test 3: single step, step outside FETCH dropped
    clear_rom();
    rom[0] = 16'h9105;
    rom[1] = 16'h1000;
    run = 1'b0;
    do_reset();
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (state != 3'd0 || pc != 8'd0) ok = 1'b0;
      tick();
    end
    check("t3_hold", ok, 1);
    step = 1'b1;
    tick();
    step = 1'b0;
    check("t3_step_fwait", state, 1);
    tick(2);
    check("t3_step_wb", rf_we, 1);
    tick();
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (state != 3'd0 || pc != 8'd1) ok = 1'b0;
      tick();
    end
    check("t3_one_instr", ok, 1);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick(2);
    check("t3_exec", state, 3);
    step = 1'b1;
    tick();
    step = 1'b0;
    check("t3_add_wb", rf_we, 1);
    tick();
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (state != 3'd0 || pc != 8'd2) ok = 1'b0;
      tick();
    end
    check("t3_exec_step_ignored", ok, 1);

    // test 4: STORE, LDM, PRINT, HALT
    clear_rom();
    rom[0] = 16'hA203;
    rom[1] = 16'hC003;
    rom[2] = 16'hB000;
    rom[3] = 16'hF000;
    run = 1'b1;
    do_reset();
    n_ram = 0; n_rf = 0; n_out = 0; n_ovl = 0;
    ram_a = '0; rf_a = '0; rf_s = '0; rf_w = '1; rs_sel = '0;
    for (int i = 0; i < 30; i++) begin
      if (ram_we) begin n_ram++; ram_a = ram_addr; rs_sel = rf_rsel; end
      if (rf_we) begin n_rf++; rf_a = ram_addr; rf_s = rf_src; rf_w = rf_wsel; end
      if (out_we) n_out++;
      if (int'(rf_we) + int'(ram_we) + int'(out_we) > 1) n_ovl++;
      tick();
    end
    check("t4_ram_we_cnt", n_ram, 1);
    check("t4_ram_addr", ram_a, 3);
    check("t4_store_rsel", rs_sel, 2);
    check("t4_rf_we_cnt", n_rf, 1);
    check("t4_ldm_src", rf_s, 2);
    check("t4_ldm_addr", rf_a, 3);
    check("t4_ldm_wsel", rf_w, 0);
    check("t4_out_we_cnt", n_out, 1);
    check("t4_overlap", n_ovl, 0);
    check("t4_halted", halted, 1);
    check("t4_state", state, 7);
    pc_hold = pc;
    check("t4_halt_pc", pc_hold, 3);
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step = i[0];
      run = i[1];
      if (pc != pc_hold || !halted || rf_we || ram_we || out_we) ok = 1'b0;
      tick();
    end
    step = 1'b0;
    run = 1'b1;
    check("t4_halt_stays", ok, 1);

    // test 5: PC wrap after LOAD at 8'hFF
    clear_rom();
    rom[255] = 16'h9105;
    do_reset();
    cyc = 1;
    while (state != 3'd4 && cyc < 1000) begin
      tick();
      cyc++;
    end
    check("t5_wb_cycle", cyc, 769);
    check("t5_pc_wrap", pc, 0);
    check("t5_imm", imm, 5);
    tick();
    check("t5_rom_addr", {state, rom_addr}, {3'd0, 8'd0});

    // test 6: reset in WB of an ALU op, then sticky illegal
    clear_rom();
    rom[0] = 16'h1000;
    rom[1] = 16'hE000;
    do_reset();
    tick(4);
    check("t6_in_wb", state, 4);
    rst = 1'b1;
    #1;
    check("t6_rf_we_suppressed", rf_we, 0);
    tick();
    rst = 1'b0;
    check("t6_after_rst", {state, pc, rf_we}, {3'd0, 8'd0, 1'b0});
    check("t6_illegal_clear", illegal, 0);
    tick(7);
    check("t6_illegal_not_yet", illegal, 0);
    tick();
    check("t6_illegal_set", illegal, 1);
    tick(20);
    check("t6_illegal_sticky", illegal, 1);
    do_reset();
    check("t6_illegal_rst", illegal, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
